// File: rtl/tpu_core_param.sv
// NxN signed matrix-multiply core: byte-serial buffer loads, fixed-latency compute,
// and a row-major valid/ready result stream with saturation and optional ReLU.
module tpu_core_param #(
    parameter int unsigned N     = 2,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 2 * DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] ui_in,
    input  logic          fetch_w,
    input  logic          fetch_inp,
    input  logic          start,
    input  logic          relu_en,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);
    localparam int unsigned NN = N * N;
    localparam int unsigned PW = $clog2(NN);
    localparam int unsigned CW = $clog2(3 * N);
    localparam logic [PW-1:0] LastIdx = PW'(NN - 1);
    localparam logic [CW-1:0] LastCnt = CW'(3 * N - 2);
    localparam logic signed [ACC_W-1:0] SatMax = ACC_W'((1 << (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCompute = 2'd1;
    localparam logic [1:0] StOut     = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] w_q [NN];
    logic [DW-1:0] w_d [NN];
    logic [DW-1:0] x_q [NN];
    logic [DW-1:0] x_d [NN];
    logic [PW-1:0] w_ptr_q, w_ptr_d, x_ptr_q, x_ptr_d, e_q, e_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          relu_q, relu_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;

    // One result element at a time: element 0 while computing, otherwise the next in order.
    logic [PW-1:0]           sel;
    int unsigned             row, col;
    logic signed [ACC_W-1:0] acc, a_ext, b_ext;
    logic [DW-1:0]           elem;

    always_comb begin
        sel = (state_q == StOut) ? e_q + PW'(1) : '0;
        row = 32'(sel) / N;
        col = 32'(sel) % N;
        if (row >= N) begin
            row = 0;
            col = 0;
        end
        acc   = '0;
        a_ext = '0;
        b_ext = '0;
        for (int unsigned k = 0; k < N; k++) begin
            a_ext = ACC_W'($signed(x_q[PW'(row * N + k)]));
            b_ext = ACC_W'($signed(w_q[PW'(k * N + col)]));
            acc   = acc + a_ext * b_ext;
        end
        if (relu_q && acc < 0) begin
            elem = '0;
        end else if (acc > SatMax) begin
            elem = SatMax[DW-1:0];
        end else if (acc < SatMin) begin
            elem = SatMin[DW-1:0];
        end else begin
            elem = acc[DW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        x_d         = x_q;
        w_ptr_d     = w_ptr_q;
        x_ptr_d     = x_ptr_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        relu_d      = relu_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                // Weight load wins over input load, and any load suppresses start.
                if (fetch_w) begin
                    w_d[w_ptr_q] = ui_in;
                    w_ptr_d      = (w_ptr_q == LastIdx) ? '0 : w_ptr_q + PW'(1);
                end else if (fetch_inp) begin
                    x_d[x_ptr_q] = ui_in;
                    x_ptr_d      = (x_ptr_q == LastIdx) ? '0 : x_ptr_q + PW'(1);
                end else if (start) begin
                    state_d = StCompute;
                    relu_d  = relu_en;
                    w_ptr_d = '0;
                    x_ptr_d = '0;
                    cnt_d   = '0;
                end
            end
            StCompute: begin
                if (cnt_q == LastCnt) begin
                    state_d     = StOut;
                    e_d         = '0;
                    out_data_d  = elem;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (e_q == LastIdx) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        e_d        = e_q + PW'(1);
                        out_data_d = elem;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            w_q         <= '{default: '0};
            x_q         <= '{default: '0};
            w_ptr_q     <= '0;
            x_ptr_q     <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            x_q         <= x_d;
            w_ptr_q     <= w_ptr_d;
            x_ptr_q     <= x_ptr_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_tpu_core_param.sv
// Scoreboard bench for tpu_core_param (N=2, DW=8): expected elements are queued at start
// and checked as each element is transferred on the output port.
module tb_tpu_core_param;
    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          reset;
    logic [DW-1:0] ui_in;
    logic          fetch_w, fetch_inp, start, relu_en, out_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    tpu_core_param #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ui_in    (ui_in),
        .fetch_w  (fetch_w),
        .fetch_inp(fetch_inp),
        .start    (start),
        .relu_en  (relu_en),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_w(input int v);
        fetch_w = 1'b1;
        ui_in   = DW'(v);
        tick();
        fetch_w = 1'b0;
    endtask

    task automatic load_x(input int v);
        fetch_inp = 1'b1;
        ui_in     = DW'(v);
        tick();
        fetch_inp = 1'b0;
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    // Start a run, then drain the scoreboard, optionally stalling after the first valid.
    task automatic run(input bit relu, input int stall);
        int t0;
        int budget;
        int e;
        relu_en = relu;
        start   = 1'b1;
        t0      = cyc;
        tick();
        start   = 1'b0;
        relu_en = ~relu;
        check_eq("busy_in_compute", int'(busy), 1);
        budget = 0;
        while (out_valid !== 1'b1 && budget < 40) begin
            tick();
            budget++;
        end
        check_eq("first_valid_latency", cyc - t0, 3 * N);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            check_eq("stall_valid", int'(out_valid), 1);
            check_eq("stall_hold", sdata(), exp_q[0]);
            tick();
        end
        out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 40) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                check_eq("out_data", sdata(), e);
            end
            tick();
            budget++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout_left", exp_q.size(), 0);
            exp_q.delete();
        end
        check_eq("done_pulse", int'(done), 1);
        check_eq("done_latency", cyc - t0, 3 * N + N * N + stall);
        check_eq("valid_after_last", int'(out_valid), 0);
        check_eq("busy_after_last", int'(busy), 0);
        tick();
        check_eq("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int seen;
        reset     = 1'b0;
        ui_in     = '0;
        fetch_w   = 1'b0;
        fetch_inp = 1'b0;
        start     = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_out_data", sdata(), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        reset = 1'b1;
        tick();
        check_eq("idle_busy", int'(busy), 0);

        // Basic product, then a rerun without reload under backpressure.
        load_w(1); load_w(2); load_w(3); load_w(4);
        load_x(5); load_x(6); load_x(7); load_x(8);
        push4(23, 34, 31, 46);
        run(1'b0, 0);
        push4(23, 34, 31, 46);
        run(1'b0, 3);

        // Saturation both ways.
        for (int i = 0; i < 4; i++) load_w(127);
        for (int i = 0; i < 4; i++) load_x(127);
        push4(127, 127, 127, 127);
        run(1'b0, 0);
        for (int i = 0; i < 4; i++) load_x(-128);
        push4(-128, -128, -128, -128);
        run(1'b0, 0);

        // ReLU on and off over the same buffers.
        load_w(-1); load_w(0); load_w(0); load_w(-1);
        load_x(3); load_x(-4); load_x(5); load_x(6);
        push4(0, 4, 0, 0);
        run(1'b1, 0);
        push4(-3, 4, -5, -6);
        run(1'b0, 0);

        // Pointer wrap, fetch priority and start suppressed by a load.
        load_w(9); load_w(2); load_w(3); load_w(4); load_w(7);
        load_x(5); load_x(6); load_x(7); load_x(8);
        fetch_w   = 1'b1;
        fetch_inp = 1'b1;
        ui_in     = 8'd1;
        tick();
        fetch_w   = 1'b0;
        fetch_inp = 1'b0;
        fetch_w   = 1'b1;
        start     = 1'b1;
        ui_in     = 8'd2;
        tick();
        fetch_w   = 1'b0;
        start     = 1'b0;
        check_eq("start_with_fetch_busy", int'(busy), 0);
        tick();
        check_eq("start_with_fetch_valid", int'(out_valid), 0);
        push4(47, 29, 65, 39);
        run(1'b0, 0);

        // Reset during COMPUTE.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_out_data", sdata(), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_valid", int'(out_valid), 0);
        tick();
        reset = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        check_eq("no_valid_after_reset", seen, 0);
        push4(0, 0, 0, 0);
        run(1'b0, 0);
        load_w(1); load_w(2); load_w(3); load_w(4);
        load_x(5); load_x(6); load_x(7); load_x(8);
        push4(23, 34, 31, 46);
        run(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
